// File: rtl/fft_out_reorder.sv
// fft_out_reorder: receives the 16-point FFT core's results in bit-reversed
// order into a ping-pong buffer and streams each frame out in natural order,
// tagged with frequency index and a last-sample flag.
module fft_out_reorder #(
    parameter int WIDTH  = 16,
    parameter int LOG2N  = 4,
    parameter bit BITREV = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_push,
    input  logic signed [WIDTH-1:0] in_real,
    input  logic signed [WIDTH-1:0] in_imag,
    output logic                    in_stall,
    output logic                    out_push_F,
    output logic signed [WIDTH-1:0] out_real_F,
    output logic signed [WIDTH-1:0] out_imag_F,
    output logic [LOG2N-1:0]        out_index_F,
    output logic                    out_last_F,
    input  logic                    out_stall
);

    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LAST = {LOG2N{1'b1}};

    typedef enum logic {IDLE, STREAM} rd_state_t;

    // Two banks of N samples, bank selected by the address MSB.
    logic [2*WIDTH-1:0] mem [2*N];

    rd_state_t        state, state_nxt;
    logic             wr_bank, rd_bank;
    logic [LOG2N-1:0] wr_cnt, rd_cnt, wr_addr;
    logic [1:0]       full, full_nxt;
    logic             wr_acc, wr_done;
    logic             cur_ready, other_ready;
    logic             rd_issue, rd_done;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = k[LOG2N-1-i];
        return r;
    endfunction

    // Stall depends only on registers: the bank about to be written is still unread.
    assign in_stall = full[wr_bank];
    assign wr_acc   = in_push && !in_stall;
    assign wr_done  = wr_acc && (wr_cnt == LAST);
    assign wr_addr  = BITREV ? bitrev(wr_cnt) : wr_cnt;

    // A bank counts as ready in the same cycle its final sample is written, so
    // the first output appears two cycles after the frame completes.
    assign cur_ready   = full[rd_bank] || (wr_done && (wr_bank == rd_bank));
    assign other_ready = full[~rd_bank] || (wr_done && (wr_bank != rd_bank));

    // Read FSM next state, issue strobe and full-flag updates.
    always_comb begin
        state_nxt = state;
        rd_issue  = 1'b0;
        rd_done   = 1'b0;
        full_nxt  = full;
        case (state)
            IDLE: begin
                if (cur_ready) state_nxt = STREAM;
            end
            STREAM: begin
                if (!out_stall) begin
                    rd_issue = 1'b1;
                    if (rd_cnt == LAST) begin
                        rd_done = 1'b1;
                        if (!other_ready) state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Read clears and write sets always address different banks.
        if (rd_done) full_nxt[rd_bank] = 1'b0;
        if (wr_done) full_nxt[wr_bank] = 1'b1;
    end

    // Control registers: FSM state, bank pointers, counters and full flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            full    <= '0;
        end else begin
            state <= state_nxt;
            full  <= full_nxt;
            if (wr_acc) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_done) wr_bank <= ~wr_bank;
            end
            if (rd_issue) rd_cnt <= rd_cnt + 1'b1;
            if (rd_done) rd_bank <= ~rd_bank;
        end
    end

    // Sample storage; contents survive reset because the full flags gate their use.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[{wr_bank, wr_addr}] <= {in_real, in_imag};
    end

    // Output registers; data and index hold while backpressure suppresses a push.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_push_F  <= 1'b0;
            out_last_F  <= 1'b0;
            out_real_F  <= '0;
            out_imag_F  <= '0;
            out_index_F <= '0;
        end else begin
            out_push_F <= rd_issue;
            out_last_F <= rd_issue && (rd_cnt == LAST);
            if (rd_issue) begin
                {out_real_F, out_imag_F} <= mem[{rd_bank, rd_cnt}];
                out_index_F              <= rd_cnt;
            end
        end
    end

endmodule
